cache_rd_arbiter: RTL and testbench

CACHE_RD_ARBITER -- requirements
Module: cache_rd_arbiter

---
 rtl/cache_rd_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_cache_rd_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_rd_arbiter.sv
// -----------------------------------------------------------------------------
// cache_rd_arbiter
//
// Shares one read port toward the AXI bridge between the icache and the
// dcache. Exactly one read is outstanding at a time: IDLE picks a winner and
// latches its request, REQ presents it on the m_ port until m_rd_rdy, and RESP
// forwards return beats to the latched owner until m_ret_last.
//
// Ports
//   clock, resetn         single clock, asynchronous active-low reset
//   i_rd_* / i_ret_*      icache read request / return
//   d_rd_* / d_ret_*      dcache read request / return
//   m_rd_* / m_ret_*      shared read request / return toward the AXI bridge
//   busy                  high whenever the arbiter is not in IDLE
//   proto_err             sticky flag for return-beat-count violations and
//                         stray return beats outside RESP
//
// Parameters
//   LINE_BEATS            beats returned for rd_type 3'b100 (cache line);
//                         every other rd_type returns a single beat
//
// Configuration
//   CACHE_RD_ARB_ROUND_ROBIN_EN  when defined, ties alternate using a 1-bit
//                         last-winner register (dcache wins the first tie);
//                         when undefined, dcache always wins ties.
//
// resetn must be deasserted synchronously to clock by the reset generator.
// -----------------------------------------------------------------------------
module cache_rd_arbiter #(
    parameter int LINE_BEATS = 4
) (
    input  logic        clock,
    input  logic        resetn,

    input  logic        i_rd_req,
    input  logic [2:0]  i_rd_type,
    input  logic [31:0] i_rd_addr,
    output logic        i_rd_rdy,
    output logic        i_ret_valid,
    output logic        i_ret_last,
    output logic [31:0] i_ret_data,

    input  logic        d_rd_req,
    input  logic [2:0]  d_rd_type,
    input  logic [31:0] d_rd_addr,
    output logic        d_rd_rdy,
    output logic        d_ret_valid,
    output logic        d_ret_last,
    output logic [31:0] d_ret_data,

    output logic        m_rd_req,
    output logic [2:0]  m_rd_type,
    output logic [31:0] m_rd_addr,
    input  logic        m_rd_rdy,
    input  logic        m_ret_valid,
    input  logic        m_ret_last,
    input  logic [31:0] m_ret_data,

    output logic        busy,
    output logic        proto_err
);

    localparam int         CW        = $clog2(LINE_BEATS + 1);
    localparam logic [2:0] TYPE_LINE = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t        state, state_nxt;
    logic          owner, owner_nxt;      // 0 = icache, 1 = dcache
    logic [2:0]    type_q, type_nxt;
    logic [31:0]   addr_q, addr_nxt;
    logic [CW-1:0] cnt, cnt_nxt;          // return beats still expected
    logic          err, err_nxt;
    logic          grant_d;               // IDLE arbitration result: 1 = dcache

`ifdef CACHE_RD_ARB_ROUND_ROBIN_EN
    logic last_win;                       // 0 = icache won last, 1 = dcache

    // On a tie the requester that did not win last is granted.
    assign grant_d = d_rd_req & (~i_rd_req | ~last_win);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_win <= 1'b0;
        end else if (state == IDLE && (i_rd_req || d_rd_req)) begin
            last_win <= grant_d;
        end
    end
`else
    // Fixed priority: dcache wins every tie.
    assign grant_d = d_rd_req;
`endif

    // NOTE: every variable assigned in this block gets a default first, so no
    // path through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        type_nxt  = type_q;
        addr_nxt  = addr_q;
        cnt_nxt   = cnt;
        err_nxt   = err;

        case (state)
            IDLE: begin
                // A return beat with nothing outstanding is dropped.
                if (m_ret_valid) err_nxt = 1'b1;
                if (i_rd_req || d_rd_req) begin
                    owner_nxt = grant_d;
                    type_nxt  = grant_d ? d_rd_type : i_rd_type;
                    addr_nxt  = grant_d ? d_rd_addr : i_rd_addr;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (m_ret_valid) err_nxt = 1'b1;
                // The request stays issued even if the owner drops its req.
                if (m_rd_rdy) begin
                    cnt_nxt   = (type_q == TYPE_LINE) ? CW'(LINE_BEATS) : CW'(1);
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (m_ret_valid) begin
                    if (cnt != '0) cnt_nxt = cnt - CW'(1);
                    // Last on the wrong beat, or the final expected beat
                    // arriving without last; forwarding continues either way.
                    if (m_ret_last ? (cnt != CW'(1)) : (cnt == CW'(1))) err_nxt = 1'b1;
                    if (m_ret_last) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    // NOTE: every register, including the latched request, is reset so the m_
    // outputs are defined zero straight out of reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            owner  <= 1'b0;
            type_q <= '0;
            addr_q <= '0;
            cnt    <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            type_q <= type_nxt;
            addr_q <= addr_nxt;
            cnt    <= cnt_nxt;
            err    <= err_nxt;
        end
    end

    always_comb begin
        i_rd_rdy    = 1'b0;
        d_rd_rdy    = 1'b0;
        i_ret_valid = 1'b0;
        i_ret_last  = 1'b0;
        d_ret_valid = 1'b0;
        d_ret_last  = 1'b0;

        if (state == REQ) begin
            i_rd_rdy = ~owner & m_rd_rdy;
            d_rd_rdy =  owner & m_rd_rdy;
        end
        if (state == RESP) begin
            i_ret_valid = ~owner & m_ret_valid;
            i_ret_last  = ~owner & m_ret_last;
            d_ret_valid =  owner & m_ret_valid;
            d_ret_last  =  owner & m_ret_last;
        end
    end

    // Data is qualified by *_ret_valid, so it can fan out to both caches.
    assign i_ret_data = m_ret_data;
    assign d_ret_data = m_ret_data;

    assign m_rd_req  = (state == REQ);
    assign m_rd_type = type_q;
    assign m_rd_addr = addr_q;
    assign busy      = (state != IDLE);
    assign proto_err = err;

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_rd_arbiter
//
// Self-checking bench for cache_rd_arbiter. The bench plays both caches and
// the AXI bridge. A transaction-level model predicts the grant winner (fixed
// priority or round-robin depending on CACHE_RD_ARB_ROUND_ROBIN_EN), the
// address/type presented on the m_ port, the beat routing and the sticky
// proto_err flag. Directed cases are followed by randomized transactions.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cache_rd_arbiter;

    localparam int LB = 4;

    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic        i_rd_req = 1'b0, d_rd_req = 1'b0;
    logic [2:0]  i_rd_type = '0, d_rd_type = '0;
    logic [31:0] i_rd_addr = '0, d_rd_addr = '0;
    logic        i_rd_rdy, d_rd_rdy;
    logic        i_ret_valid, i_ret_last, d_ret_valid, d_ret_last;
    logic [31:0] i_ret_data, d_ret_data;
    logic        m_rd_req;
    logic [2:0]  m_rd_type;
    logic [31:0] m_rd_addr;
    logic        m_rd_rdy = 1'b0, m_ret_valid = 1'b0, m_ret_last = 1'b0;
    logic [31:0] m_ret_data = '0;
    logic        busy, proto_err;

    cache_rd_arbiter #(.LINE_BEATS(LB)) dut (
        .clock(clock), .resetn(resetn),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
        .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
        .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
        .m_rd_req(m_rd_req), .m_rd_type(m_rd_type), .m_rd_addr(m_rd_addr), .m_rd_rdy(m_rd_rdy),
        .m_ret_valid(m_ret_valid), .m_ret_last(m_ret_last), .m_ret_data(m_ret_data),
        .busy(busy), .proto_err(proto_err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    bit model_last_d = 1'b0;   // model: 1 when dcache won the previous grant
    bit exp_err      = 1'b0;   // model: expected sticky proto_err

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic bit pick_d(input bit ireq, input bit dreq);
        if (ireq && dreq) begin
`ifdef CACHE_RD_ARB_ROUND_ROBIN_EN
            return !model_last_d;
`else
            return 1'b1;
`endif
        end
        return dreq;
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        i_rd_req = 1'b0; d_rd_req = 1'b0;
        m_rd_rdy = 1'b0; m_ret_valid = 1'b0; m_ret_last = 1'b0;
        model_last_d = 1'b0;
        exp_err = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_m_rd_req", m_rd_req, 0);
        check("rst_m_rd_addr", m_rd_addr, 0);
        check("rst_m_rd_type", m_rd_type, 0);
        check("rst_i_rd_rdy", i_rd_rdy, 0);
        check("rst_d_rd_rdy", d_rd_rdy, 0);
        check("rst_i_ret_valid", i_ret_valid, 0);
        check("rst_d_ret_valid", d_ret_valid, 0);
        check("rst_i_ret_last", i_ret_last, 0);
        check("rst_d_ret_last", d_ret_last, 0);
        step();
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("post_rst_i_valid", i_ret_valid, 0);
            check("post_rst_d_valid", d_ret_valid, 0);
            check("post_rst_busy", busy, 0);
        end
    endtask

    // One transaction, entered just after a rising edge with the DUT in IDLE.
    //   hold      : keep requests asserted through REQ/RESP
    //   rdy_wait  : cycles of m_rd_rdy=0 before the handshake
    //   last_at   : beat carrying m_ret_last (0 = the correct beat)
    //   max_gap   : max idle cycles inserted before each beat
    //   data_base : nonzero selects data_base+n for beat n, else random data
    //   abort_at  : nonzero pulses reset after that many beats
    task automatic txn(input bit ireq, input bit dreq,
                       input logic [2:0] itype, input logic [2:0] dtype,
                       input logic [31:0] iaddr, input logic [31:0] daddr,
                       input bit hold, input int rdy_wait, input int last_at,
                       input int max_gap, input logic [31:0] data_base,
                       input int abort_at);
        bit          win_d;
        logic [2:0]  etype;
        logic [31:0] eaddr;
        logic [31:0] data;
        int          nb;
        int          last_idx;
        bit          rdy_now;

        i_rd_req = ireq; d_rd_req = dreq;
        i_rd_type = itype; d_rd_type = dtype;
        i_rd_addr = iaddr; d_rd_addr = daddr;
        win_d        = pick_d(ireq, dreq);
        model_last_d = win_d;
        etype    = win_d ? dtype : itype;
        eaddr    = win_d ? daddr : iaddr;
        nb       = (etype == 3'b100) ? LB : 1;
        last_idx = (last_at == 0) ? nb : last_at;
        #1;
        check("idle_busy", busy, 0);
        check("idle_i_rdy", i_rd_rdy, 0);
        check("idle_d_rdy", d_rd_rdy, 0);
        check("idle_m_req", m_rd_req, 0);
        step();

        for (int k = 0; k <= rdy_wait; k++) begin
            rdy_now  = (k == rdy_wait);
            m_rd_rdy = rdy_now;
            if (!hold && k > 0) begin
                i_rd_req = 1'b0;
                d_rd_req = 1'b0;
            end
            #1;
            check("req_m_req", m_rd_req, 1);
            check("req_m_addr", m_rd_addr, eaddr);
            check("req_m_type", {29'd0, m_rd_type}, {29'd0, etype});
            check("req_i_rdy", i_rd_rdy, !win_d && rdy_now);
            check("req_d_rdy", d_rd_rdy, win_d && rdy_now);
            step();
        end
        m_rd_rdy = 1'b0;
        if (!hold) begin
            i_rd_req = 1'b0;
            d_rd_req = 1'b0;
        end

        for (int b = 1; b <= last_idx; b++) begin
            int gap;
            if (abort_at != 0 && b == abort_at + 1) begin
                do_reset();
                return;
            end
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int g = 0; g < gap; g++) begin
                m_ret_valid = 1'b0;
                m_ret_last  = 1'b0;
                #1;
                check("gap_i_valid", i_ret_valid, 0);
                check("gap_d_valid", d_ret_valid, 0);
                check("gap_busy", busy, 1);
                step();
            end
            data        = (data_base != 0) ? data_base + 32'(b - 1) : $urandom;
            m_ret_valid = 1'b1;
            m_ret_last  = (b == last_idx);
            m_ret_data  = data;
            if ((b == last_idx) ? (b != nb) : (b >= nb)) exp_err = 1'b1;
            #1;
            check("ret_i_valid", i_ret_valid, !win_d);
            check("ret_d_valid", d_ret_valid, win_d);
            check("ret_i_last", i_ret_last, !win_d && (b == last_idx));
            check("ret_d_last", d_ret_last, win_d && (b == last_idx));
            if (win_d) check("ret_d_data", d_ret_data, data);
            else       check("ret_i_data", i_ret_data, data);
            step();
        end
        m_ret_valid = 1'b0;
        m_ret_last  = 1'b0;
        #1;
        check("done_busy", busy, 0);
        check("done_proto_err", proto_err, exp_err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        do_reset();

        // Single icache line read with fixed data 0xA0..0xA3.
        txn(1'b1, 1'b0, 3'b100, 3'b000, 32'h1000, 32'h0, 1'b0, 0, 0, 0, 32'hA0, 0);

        // Uncached dcache word read.
        txn(1'b0, 1'b1, 3'b000, 3'b010, 32'h0, 32'h3000, 1'b0, 0, 0, 0, 32'h55AA, 0);

        // Ties with both requests held across three transactions.
        do_reset();
        for (int t = 0; t < 3; t++)
            txn(1'b1, 1'b1, 3'b100, 3'b100, 32'h1000, 32'h2000, 1'b1, t, 0, 1, 32'h0, 0);
        i_rd_req = 1'b0;
        d_rd_req = 1'b0;

        // Early last on beat 2 of a line read; flag must stay set.
        txn(1'b1, 1'b0, 3'b100, 3'b000, 32'h4000, 32'h0, 1'b0, 1, 2, 0, 32'h0, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("err_hold", proto_err, exp_err);
            check("err_idle_busy", busy, 0);
        end

        // Missing last on a single-beat read; forwarding continues to last.
        do_reset();
        txn(1'b0, 1'b1, 3'b000, 3'b010, 32'h0, 32'h5000, 1'b0, 0, 3, 0, 32'h0, 0);

        // Stray return beat in IDLE is dropped and flagged.
        do_reset();
        m_ret_valid = 1'b1;
        m_ret_last  = 1'b1;
        #1;
        check("stray_i_valid", i_ret_valid, 0);
        check("stray_d_valid", d_ret_valid, 0);
        step();
        m_ret_valid = 1'b0;
        m_ret_last  = 1'b0;
        exp_err     = 1'b1;
        #1;
        check("stray_proto_err", proto_err, exp_err);

        // Reset after beat 2 of a line read, then a normal read.
        txn(1'b1, 1'b0, 3'b100, 3'b000, 32'h6000, 32'h0, 1'b0, 0, 0, 0, 32'h0, 2);
        txn(1'b1, 1'b0, 3'b100, 3'b000, 32'h7000, 32'h0, 1'b0, 0, 0, 0, 32'h0, 0);

        // Randomized well-formed traffic.
        for (int n = 0; n < 60; n++) begin
            bit          ir, dr;
            logic [2:0]  it, dt;
            int          sel;
            sel = int'($urandom_range(2, 0));
            ir  = (sel != 1);
            dr  = (sel != 0);
            it  = ($urandom_range(1, 0) == 1) ? 3'b100 : 3'($urandom_range(7, 0));
            dt  = ($urandom_range(1, 0) == 1) ? 3'b100 : 3'($urandom_range(7, 0));
            txn(ir, dr, it, dt, $urandom, $urandom, 1'($urandom_range(1, 0)),
                int'($urandom_range(3, 0)), 0, 2, 32'h0, 0);
            i_rd_req = 1'b0;
            d_rd_req = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
